fetch_issue: RTL and testbench



---
 rtl/proc_pkg.sv | 47 ++++
 rtl/instr_fields.sv | 22 ++
 rtl/fetch_issue.sv | 122 ++++++++++++
 tb/tb_fetch_issue.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// Shared definitions for the 10-bit processor front end: opcodes, field positions,
// halt encoding and the fetch state type.
package proc_pkg;

  // Opcode values carried in instr[9:6]
  localparam logic [3:0] OP_RESULT   = 4'd0;
  localparam logic [3:0] OP_SETIMM   = 4'd1;
  localparam logic [3:0] OP_LOADQ    = 4'd2;
  localparam logic [3:0] OP_COMPARE  = 4'd3;
  localparam logic [3:0] OP_JUMPINIT = 4'd4;
  localparam logic [3:0] OP_INCR     = 4'd5;
  localparam logic [3:0] OP_IFDONE   = 4'd6;
  localparam logic [3:0] OP_STOREZ   = 4'd7;
  localparam logic [3:0] OP_SETARG   = 4'd8;
  localparam logic [3:0] OP_JUMPFP   = 4'd9;
  localparam logic [3:0] OP_SKIPNE1  = 4'd10;
  localparam logic [3:0] OP_PUSH     = 4'd11;
  localparam logic [3:0] OP_POP      = 4'd12;
  localparam logic [3:0] OP_SETTEMP  = 4'd13;
  localparam logic [3:0] OP_RETURN   = 4'd14;

  // Field bit positions within the instruction word
  localparam int unsigned OPCODE_MSB = 9;
  localparam int unsigned OPCODE_LSB = 6;
  localparam int unsigned FTO_MSB    = 5;
  localparam int unsigned FTO_LSB    = 1;
  localparam int unsigned OTZ_MSB    = 1;
  localparam int unsigned OTZ_LSB    = 0;
  localparam int unsigned ARG2_BIT   = 1;
  localparam int unsigned BIT0_BIT   = 0;

  // Opcode 0 with this function value halts the machine
  localparam logic [4:0] HALT_FUNC = 5'd4;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StWait,
    StValid,
    StHalt
  } fetch_state_e;

  function automatic logic is_halt(input logic [3:0] op, input logic [4:0] func);
    return (op == OP_RESULT) && (func == HALT_FUNC);
  endfunction

endpackage

// File: rtl/instr_fields.sv
// Combinational split of a 10-bit instruction word into decoder fields.
module instr_fields
  import proc_pkg::*;
(
  input  logic [9:0] instr,
  output logic [3:0] opcode,
  output logic [4:0] five_to_one,
  output logic [1:0] one_to_zero,
  output logic       arg2,
  output logic       bit0
);

  // Pure wiring; fields overlap on bits 1 and 0 by design
  always_comb begin
    opcode      = instr[OPCODE_MSB:OPCODE_LSB];
    five_to_one = instr[FTO_MSB:FTO_LSB];
    one_to_zero = instr[OTZ_MSB:OTZ_LSB];
    arg2        = instr[ARG2_BIT];
    bit0        = instr[BIT0_BIT];
  end

endmodule

// File: rtl/fetch_issue.sv
// Fetch/issue stage: PC, synchronous instruction read, field split and valid/ready
// hand-off to the decoder, with branch redirect and halt parking.
module fetch_issue
  import proc_pkg::*;
#(
  parameter int unsigned PC_W     = 8,
  parameter int unsigned INSTR_W  = 10,
  parameter int unsigned RESET_PC = 0,
  parameter int unsigned HALT_PC  = 200
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [PC_W-1:0]    imem_addr,
  output logic               imem_rd,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [3:0]         opcode,
  output logic [4:0]         five_to_one,
  output logic [1:0]         one_to_zero,
  output logic               arg2,
  output logic               bit0,
  output logic [PC_W-1:0]    issue_pc,
  input  logic               branch_taken,
  input  logic [PC_W-1:0]    branch_target,
  output logic               halted
);

  fetch_state_e       state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [PC_W-1:0]    issue_pc_q, issue_pc_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic               handshake;
  logic               halt_word;

  instr_fields u_fields (
    .instr       (ir_q),
    .opcode      (opcode),
    .five_to_one (five_to_one),
    .one_to_zero (one_to_zero),
    .arg2        (arg2),
    .bit0        (bit0)
  );

  assign handshake = (state_q == StValid) && instr_ready;
  assign halt_word = is_halt(opcode, five_to_one);

  // Next-state, PC and capture logic; halt beats redirect, redirect beats increment
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    issue_pc_d = issue_pc_q;
    ir_d       = ir_q;
    unique case (state_q)
      StIdle: begin
        state_d = StReq;
        if (branch_taken) pc_d = branch_target;
      end
      StReq: begin
        state_d = StWait;
        // The read already launched returns during the repeated REQ and is never captured
        if (branch_taken) begin
          pc_d    = branch_target;
          state_d = StReq;
        end
      end
      StWait: begin
        if (branch_taken) begin
          pc_d    = branch_target;
          state_d = StReq;
        end else begin
          ir_d       = imem_rdata;
          issue_pc_d = pc_q;
          state_d    = StValid;
        end
      end
      StValid: begin
        if (handshake && halt_word) begin
          pc_d    = PC_W'(HALT_PC);
          state_d = StHalt;
        end else if (branch_taken) begin
          pc_d    = branch_target;
          state_d = StReq;
        end else if (handshake) begin
          pc_d    = pc_q + 1'b1;
          state_d = StReq;
        end
      end
      StHalt: begin
        state_d = StHalt;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      pc_q       <= PC_W'(RESET_PC);
      issue_pc_q <= '0;
      ir_q       <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      issue_pc_q <= issue_pc_d;
      ir_q       <= ir_d;
    end
  end

  // Outputs come from registers or state decode only
  always_comb begin
    imem_addr   = pc_q;
    imem_rd     = (state_q == StReq);
    instr_valid = (state_q == StValid);
    halted      = (state_q == StHalt);
    issue_pc    = issue_pc_q;
  end

endmodule

// File: tb/tb_fetch_issue.sv
// Self-checking bench for fetch_issue: directed scenarios then a randomized
// ready/redirect run against a transaction-level PC model.
module tb_fetch_issue;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] imem_addr;
  logic       imem_rd;
  logic [9:0] imem_rdata = '0;
  logic       instr_valid;
  logic       instr_ready;
  logic [3:0] opcode;
  logic [4:0] five_to_one;
  logic [1:0] one_to_zero;
  logic       arg2;
  logic       bit0;
  logic [7:0] issue_pc;
  logic       branch_taken;
  logic [7:0] branch_target;
  logic       halted;

  logic [9:0] mem [256];
  int checks = 0;
  int errors = 0;

  fetch_issue dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_addr     (imem_addr),
    .imem_rd       (imem_rd),
    .imem_rdata    (imem_rdata),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .opcode        (opcode),
    .five_to_one   (five_to_one),
    .one_to_zero   (one_to_zero),
    .arg2          (arg2),
    .bit0          (bit0),
    .issue_pc      (issue_pc),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .halted        (halted)
  );

  always #5 clk = ~clk;

  // Synchronous instruction memory: data appears the cycle after the strobe
  always @(posedge clk) begin
    if (imem_rd) imem_rdata <= mem[imem_addr];
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected fields computed arithmetically from the word
  task automatic chk_fields(input string tag, input logic [9:0] w);
    int wi;
    wi = int'(w);
    chk({tag, "_opcode"}, 32'(opcode), 32'((wi >> 6) & 15));
    chk({tag, "_f51"}, 32'(five_to_one), 32'((wi >> 1) & 31));
    chk({tag, "_f10"}, 32'(one_to_zero), 32'(wi & 3));
    chk({tag, "_arg2"}, 32'(arg2), 32'((wi >> 1) & 1));
    chk({tag, "_bit0"}, 32'(bit0), 32'(wi & 1));
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (instr_valid !== 1'b1 && n < 6) begin
      tick();
      n++;
    end
    chk(tag, 32'(instr_valid), 32'd1);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_valid"}, 32'(instr_valid), 32'd0);
    chk({tag, "_rd"}, 32'(imem_rd), 32'd0);
    chk({tag, "_halted"}, 32'(halted), 32'd0);
    chk({tag, "_addr"}, 32'(imem_addr), 32'd0);
    chk({tag, "_ipc"}, 32'(issue_pc), 32'd0);
    chk_fields(tag, 10'd0);
  endtask

  initial begin
    logic [7:0] mpc;
    logic       rdy;
    logic       br;
    logic [7:0] tgt;

    for (int i = 0; i < 256; i++) begin
      logic [9:0] w;
      do w = 10'($urandom_range(0, 1023)); while (w[9:6] == 4'd0 && w[5:1] == 5'd4);
      mem[i] = w;
    end
    mem[0] = 10'h040;
    mem[7] = 10'h008;

    rst_n = 1'b0; instr_ready = 1'b0; branch_taken = 1'b0; branch_target = '0;
    @(negedge clk);
    tick(); tick();
    chk_reset("reset");

    // First fetch with ready tied high
    rst_n = 1'b1; instr_ready = 1'b1;
    tick();
    chk("e0_rd", 32'(imem_rd), 32'd1);
    chk("e0_addr", 32'(imem_addr), 32'd0);
    chk("e0_valid", 32'(instr_valid), 32'd0);
    tick();
    chk("e1_rd", 32'(imem_rd), 32'd0);
    chk("e1_valid", 32'(instr_valid), 32'd0);
    tick();
    chk("e2_valid", 32'(instr_valid), 32'd1);
    chk("e2_ipc", 32'(issue_pc), 32'd0);
    chk_fields("e2", mem[0]);
    tick();
    chk("hs_rd", 32'(imem_rd), 32'd1);
    chk("hs_pc", 32'(imem_addr), 32'd1);

    // Stall in VALID
    instr_ready = 1'b0;
    tick(); tick();
    chk("stall_valid0", 32'(instr_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_valid", 32'(instr_valid), 32'd1);
      chk("stall_ipc", 32'(issue_pc), 32'd1);
      chk("stall_rd", 32'(imem_rd), 32'd0);
      chk("stall_addr", 32'(imem_addr), 32'd1);
      chk_fields("stall", mem[1]);
    end
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    chk("stall_rel_addr", 32'(imem_addr), 32'd2);

    // Redirect while WAITing: word at 2 is dropped
    tick();
    chk("wait_rd", 32'(imem_rd), 32'd0);
    branch_taken = 1'b1; branch_target = 8'h30;
    tick();
    branch_taken = 1'b0;
    chk("redir_rd", 32'(imem_rd), 32'd1);
    chk("redir_addr", 32'(imem_addr), 32'h30);
    chk("redir_valid", 32'(instr_valid), 32'd0);
    tick();
    chk("redir_valid2", 32'(instr_valid), 32'd0);
    tick();
    chk("redir_valid3", 32'(instr_valid), 32'd1);
    chk("redir_ipc", 32'(issue_pc), 32'h30);
    chk_fields("redir", mem[8'h30]);

    // Drop the held word by redirecting to 7, then halt with a competing redirect
    branch_taken = 1'b1; branch_target = 8'h07;
    tick();
    branch_taken = 1'b0;
    chk("drop_addr", 32'(imem_addr), 32'h07);
    tick(); tick();
    chk("h_valid", 32'(instr_valid), 32'd1);
    chk("h_ipc", 32'(issue_pc), 32'h07);
    chk_fields("h", mem[7]);
    instr_ready = 1'b1; branch_taken = 1'b1; branch_target = 8'h10;
    tick();
    branch_target = 8'h55;
    for (int i = 0; i < 4; i++) begin
      chk("halt_halted", 32'(halted), 32'd1);
      chk("halt_addr", 32'(imem_addr), 32'd200);
      chk("halt_rd", 32'(imem_rd), 32'd0);
      chk("halt_valid", 32'(instr_valid), 32'd0);
      tick();
    end
    branch_taken = 1'b0; instr_ready = 1'b0;

    // Reset out of HALT, redirect from IDLE to 255 and wrap
    rst_n = 1'b0;
    tick();
    chk_reset("reset2");
    rst_n = 1'b1; branch_taken = 1'b1; branch_target = 8'hFF;
    tick();
    branch_taken = 1'b0; instr_ready = 1'b1;
    chk("idle_redir_addr", 32'(imem_addr), 32'hFF);
    chk("idle_redir_rd", 32'(imem_rd), 32'd1);
    tick(); tick();
    chk("w255_ipc", 32'(issue_pc), 32'hFF);
    chk("w255_valid", 32'(instr_valid), 32'd1);
    tick();
    chk("wrap_addr", 32'(imem_addr), 32'd0);
    chk("wrap_rd", 32'(imem_rd), 32'd1);
    instr_ready = 1'b0; branch_taken = 1'b1; branch_target = 8'h20;
    tick();
    branch_taken = 1'b0;
    chk("req_redir_addr", 32'(imem_addr), 32'h20);
    chk("req_redir_rd", 32'(imem_rd), 32'd1);
    tick(); tick();
    chk("req_redir_ipc", 32'(issue_pc), 32'h20);
    chk_fields("req_redir", mem[8'h20]);

    // Reset in VALID, then restart at RESET_PC
    rst_n = 1'b0;
    tick();
    chk_reset("reset3");
    rst_n = 1'b1;
    tick();
    chk("restart_rd", 32'(imem_rd), 32'd1);
    chk("restart_addr", 32'(imem_addr), 32'd0);

    // Randomized ready/redirect run against a PC-level model
    mem[7] = 10'h040;
    mpc = 8'd0;
    for (int it = 0; it < 200; it++) begin
      wait_valid("rnd_wait");
      chk("rnd_ipc", 32'(issue_pc), 32'(mpc));
      chk_fields("rnd", mem[mpc]);
      rdy = 1'($urandom_range(0, 1));
      br  = ($urandom_range(0, 3) == 0);
      tgt = 8'($urandom_range(0, 255));
      instr_ready = rdy; branch_taken = br; branch_target = tgt;
      tick();
      instr_ready = 1'b0; branch_taken = 1'b0;
      if (rdy || br) begin
        mpc = br ? tgt : mpc + 8'd1;
        chk("rnd_rd", 32'(imem_rd), 32'd1);
        chk("rnd_addr", 32'(imem_addr), 32'(mpc));
        chk("rnd_gap0", 32'(instr_valid), 32'd0);
        tick();
        chk("rnd_gap1", 32'(instr_valid), 32'd0);
        tick();
        chk("rnd_lat", 32'(instr_valid), 32'd1);
      end else begin
        chk("rnd_hold", 32'(instr_valid), 32'd1);
        chk("rnd_hold_rd", 32'(imem_rd), 32'd0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
